// File: rtl/cache_pkg.sv
// Shared constants, address-field widths and FSM encoding for the
// direct-mapped write-back cache controller.
package cache_pkg;

  localparam int ADDR_BITS      = 32;
  localparam int WORD_BITS      = 32;
  localparam int LINE_BITS      = 128;
  localparam int WORDS_PER_LINE = LINE_BITS / WORD_BITS;
  localparam int OFFSET_BITS    = $clog2(LINE_BITS / 8);
  localparam int DEF_NUM_LINES  = 4;
  localparam int INDEX_BITS     = $clog2(DEF_NUM_LINES);
  localparam int TAG_BITS       = ADDR_BITS - INDEX_BITS - OFFSET_BITS;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COMPARE   = 2'd1,
    ST_WRITEBACK = 2'd2,
    ST_ALLOCATE  = 2'd3
  } state_e;

  // Replace one 32-bit word of a line; word 0 sits in the low bits.
  function automatic logic [LINE_BITS-1:0] put_word(input logic [LINE_BITS-1:0] line,
                                                    input logic [1:0]           sel,
                                                    input logic [WORD_BITS-1:0] word);
    logic [LINE_BITS-1:0] res;
    res = line;
    res[sel*WORD_BITS +: WORD_BITS] = word;
    return res;
  endfunction

endpackage

// File: rtl/cache_dm_ctrl_if.sv
// CPU-side and memory-side bus of the cache controller. The cache itself
// uses the slave modport; the CPU/memory environment uses master.
interface cache_dm_ctrl_if;
  import cache_pkg::*;

  logic [ADDR_BITS-1:0] cpu_address;
  logic                 cpu_valid;
  logic                 cpu_write;
  logic [WORD_BITS-1:0] cpu_wdata;
  logic [WORD_BITS-1:0] cpu_rdata;
  logic                 cpu_ready;

  logic [ADDR_BITS-1:0] mem_address;
  logic                 mem_valid;
  logic                 mem_write;
  logic [LINE_BITS-1:0] mem_in;
  logic [LINE_BITS-1:0] mem_out;
  logic                 mem_ready;

  modport master (
    output cpu_address, cpu_valid, cpu_write, cpu_wdata, mem_out, mem_ready,
    input  cpu_rdata, cpu_ready, mem_address, mem_valid, mem_write, mem_in
  );

  modport slave (
    input  cpu_address, cpu_valid, cpu_write, cpu_wdata, mem_out, mem_ready,
    output cpu_rdata, cpu_ready, mem_address, mem_valid, mem_write, mem_in
  );

endinterface

// File: rtl/cache_line_store.sv
// Tag/valid/dirty/data arrays with one registered read port and one write
// port; a same-cycle write to the read index is forwarded (write-first).
module cache_line_store #(
  parameter int NUM_LINES = 4,
  parameter int TAG_W     = 26,
  parameter int LINE_W    = 128,
  localparam int IDX_W    = $clog2(NUM_LINES)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_index_i,
  output logic              rd_valid_o,
  output logic              rd_dirty_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0] rd_line_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_index_i,
  input  logic              wr_dirty_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [LINE_W-1:0] wr_line_i
);

  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [LINE_W-1:0]    data_mem [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic                 rd_valid_q;
  logic                 rd_dirty_q;
  logic [TAG_W-1:0]     rd_tag_q;
  logic [LINE_W-1:0]    rd_line_q;
  logic                 fwd;

  assign fwd = wr_en_i && (wr_index_i == rd_index_i);

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      tag_mem[wr_index_i]  <= wr_tag_i;
      data_mem[wr_index_i] <= wr_line_i;
    end
    rd_tag_q  <= fwd ? wr_tag_i  : tag_mem[rd_index_i];
    rd_line_q <= fwd ? wr_line_i : data_mem[rd_index_i];
  end

  // Every write installs or updates a live line, so it always sets valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= '0;
      dirty_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_dirty_q <= 1'b0;
    end else begin
      if (wr_en_i) begin
        valid_q[wr_index_i] <= 1'b1;
        dirty_q[wr_index_i] <= wr_dirty_i;
      end
      rd_valid_q <= fwd ? 1'b1       : valid_q[rd_index_i];
      rd_dirty_q <= fwd ? wr_dirty_i : dirty_q[rd_index_i];
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_dirty_o = rd_dirty_q;
  assign rd_tag_o   = rd_tag_q;
  assign rd_line_o  = rd_line_q;

endmodule

// File: rtl/cache_dm_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller:
// IDLE -> COMPARE -> (WRITEBACK) -> ALLOCATE -> COMPARE.
module cache_dm_ctrl #(
  parameter int NUM_LINES = 4,
  parameter int LINE_BITS = cache_pkg::LINE_BITS
) (
  input  logic          clock,
  input  logic          reset,
  cache_dm_ctrl_if.slave bus
);
  import cache_pkg::*;

  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int IDX_LO = OFFSET_BITS;
  localparam int IDX_HI = OFFSET_BITS + IDX_W - 1;
  localparam int TAG_W  = ADDR_BITS - IDX_HI - 1;

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:2]   addr_q;
  logic                   write_q;
  logic [WORD_BITS-1:0]   wdata_q;
  logic [IDX_W-1:0]       idx_q, rd_index;
  logic [TAG_W-1:0]       tag_q, rd_tag;
  logic [1:0]             word_sel;
  logic                   rd_valid, rd_dirty, hit, accept;
  logic [LINE_BITS-1:0]   rd_line, wr_line;
  logic                   wr_en, wr_dirty;
  logic                   ready_c, mem_valid_c, mem_write_c;
  logic [ADDR_BITS-1:0]   mem_address_c;
  logic                   unused_addr_bits;

  assign idx_q    = addr_q[IDX_HI:IDX_LO];
  assign tag_q    = addr_q[ADDR_BITS-1:IDX_HI+1];
  assign word_sel = addr_q[3:2];
  assign accept   = (state_q == ST_IDLE) && bus.cpu_valid;
  assign hit      = rd_valid && (rd_tag == tag_q);
  assign unused_addr_bits = ^bus.cpu_address[1:0];

  // Look up the incoming index while idle so its line is ready in COMPARE.
  assign rd_index = (state_q == ST_IDLE) ? bus.cpu_address[IDX_HI:IDX_LO] : idx_q;

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      addr_q  <= bus.cpu_address[ADDR_BITS-1:2];
      write_q <= bus.cpu_write;
      wdata_q <= bus.cpu_wdata;
    end
  end

  always_comb begin
    state_d       = state_q;
    ready_c       = 1'b0;
    mem_valid_c   = 1'b0;
    mem_write_c   = 1'b0;
    mem_address_c = '0;
    wr_en         = 1'b0;
    wr_dirty      = 1'b0;
    wr_line       = bus.mem_out;
    case (state_q)
      ST_IDLE: begin
        if (bus.cpu_valid) state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        if (hit) begin
          ready_c = 1'b1;
          state_d = ST_IDLE;
          if (write_q) begin
            wr_en    = 1'b1;
            wr_dirty = 1'b1;
            wr_line  = put_word(rd_line, word_sel, wdata_q);
          end
        end else if (rd_valid && rd_dirty) begin
          state_d = ST_WRITEBACK;
        end else begin
          state_d = ST_ALLOCATE;
        end
      end
      ST_WRITEBACK: begin
        mem_valid_c   = 1'b1;
        mem_write_c   = 1'b1;
        mem_address_c = {rd_tag, idx_q, {OFFSET_BITS{1'b0}}};
        if (bus.mem_ready) state_d = ST_ALLOCATE;
      end
      ST_ALLOCATE: begin
        mem_valid_c   = 1'b1;
        mem_address_c = {tag_q, idx_q, {OFFSET_BITS{1'b0}}};
        if (bus.mem_ready) begin
          wr_en   = 1'b1;
          state_d = ST_COMPARE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  cache_line_store #(
    .NUM_LINES (NUM_LINES),
    .TAG_W     (TAG_W),
    .LINE_W    (LINE_BITS)
  ) u_store (
    .clock      (clock),
    .reset      (reset),
    .rd_index_i (rd_index),
    .rd_valid_o (rd_valid),
    .rd_dirty_o (rd_dirty),
    .rd_tag_o   (rd_tag),
    .rd_line_o  (rd_line),
    .wr_en_i    (wr_en),
    .wr_index_i (idx_q),
    .wr_dirty_i (wr_dirty),
    .wr_tag_i   (tag_q),
    .wr_line_i  (wr_line)
  );

  assign bus.cpu_ready   = ready_c;
  assign bus.cpu_rdata   = rd_line[word_sel*WORD_BITS +: WORD_BITS];
  assign bus.mem_valid   = mem_valid_c;
  assign bus.mem_write   = mem_write_c;
  assign bus.mem_address = mem_address_c;
  assign bus.mem_in      = rd_line;

endmodule

// File: doc/cache_dm_ctrl.md
CACHE_DM_CTRL -- requirements
Module: cache_dm_ctrl

Interface
REQ-001 Parameter NUM_LINES, default 4, number of direct-mapped lines (power of 2).
REQ-002 Parameter LINE_BITS, default 128, line width; fixed at 4 x 32-bit words.
REQ-003 clock  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cpu_address  in  32  CPU byte address; [3:2] word select, [5:4] index, [31:6] tag at default NUM_LINES.
REQ-006 cpu_valid  in  1  CPU request present.
REQ-007 cpu_write  in  1  1 = store, 0 = load.
REQ-008 cpu_wdata  in  32  store data.
REQ-009 cpu_rdata  out  32  load data, valid while cpu_ready=1.
REQ-010 cpu_ready  out  1  one-cycle completion pulse per accepted request.
REQ-011 mem_address  out  32  line-aligned byte address to the 128-bit memory ([3:0]=0).
REQ-012 mem_valid  out  1  memory transaction request.
REQ-013 mem_write  out  1  1 = line writeback, 0 = line fill.
REQ-014 mem_in  out  128  writeback line; word 0 in [31:0], word 3 in [127:96].
REQ-015 mem_out  in  128  fill line, same word ordering; sampled when mem_ready=1.
REQ-016 mem_ready  in  1  one-cycle memory completion pulse.

Function
REQ-017 The block SHALL be a write-back, write-allocate, direct-mapped cache with per-line valid bit, dirty bit and tag.
REQ-018 FSM states SHALL be IDLE, COMPARE, WRITEBACK, ALLOCATE.
REQ-019 IDLE: on cpu_valid=1, latch address/write/wdata, go to COMPARE; cpu_valid in any other state SHALL be ignored.
REQ-020 COMPARE hit (valid and tag match): assert cpu_ready that cycle; load drives cpu_rdata from the selected word; store writes the selected word and sets dirty; next state IDLE.
REQ-021 COMPARE miss: go to WRITEBACK if line valid and dirty, else ALLOCATE.
REQ-022 WRITEBACK: mem_valid=1, mem_write=1, mem_address={stored tag, index, 4'h0}, mem_in=stored line; on mem_ready go to ALLOCATE.
REQ-023 ALLOCATE: mem_valid=1, mem_write=0, mem_address={latched tag, index, 4'h0}; on mem_ready install mem_out, set valid, clear dirty, write tag, go to COMPARE.
REQ-024 mem_valid/mem_write/mem_address/mem_in SHALL be decoded from state and held stable from assertion through the mem_ready cycle; mem_valid SHALL be 0 in IDLE and COMPARE.
REQ-025 Hit latency SHALL be 1 cycle after acceptance; miss latency SHALL be 1 + fill (+ writeback) + 1 cycles.
REQ-026 cpu_ready SHALL be asserted only in COMPARE on a hit; exactly one pulse per accepted request.
REQ-027 mem_ready outside WRITEBACK/ALLOCATE SHALL be ignored.

Reset
REQ-028 Reset SHALL force state IDLE, clear all valid and dirty bits, and drive cpu_ready=0, mem_valid=0, mem_write=0 on the following cycle.
REQ-029 Reset mid-transaction SHALL abandon it without completing cpu_ready; tags and data arrays need no reset; cpu_rdata, mem_address, mem_in are don't-care while their qualifiers are 0.

Structure
REQ-030 Shared package cache_pkg SHALL hold the state encoding, WORD_BITS, LINE_BITS, OFFSET_BITS, INDEX_BITS and TAG_BITS derivations.
REQ-031 Tag/valid/dirty/data arrays SHALL live in one sub-module cache_line_store with one read port and one write port.

Verification (memory model: 8-cycle wait, ready pulse)
REQ-032 Reset, load 0x00000008 -> ALLOCATE with mem_address=0x00000000, mem_write=0; cpu_rdata=mem word 2; one cpu_ready pulse.
REQ-033 Then load 0x0000000C -> cpu_ready 1 cycle after acceptance, mem_valid never asserted.
REQ-034 Store 0xDEADBEEF to 0x0000000C, then load 0x0000004C -> writeback to 0x00000000 with mem_in[127:96]=0xDEADBEEF, then fill from 0x00000040.
REQ-035 Reset asserted during ALLOCATE -> next cycle mem_valid=0, cpu_ready=0; reload of 0x00000008 misses again.
REQ-036 cpu_valid held high for three back-to-back hits -> each accepted only in IDLE, exactly three cpu_ready pulses.
